cci_mpf_fiu_mem_responder: RTL and testbench

// - FIU-side responder for cci_mpf_if: connects to an AFU-facing cci_mpf_if (to_afu modport) and services CCI requests from a local line memory.
// - c0Tx reads produce c0Rx read responses. c1Tx writes and write fences produce c1Rx write responses.
// - Drives c0TxAlmFull/c1TxAlmFull flow control.
// - Used as a platform stand-in for shim-level simulation and loopback bring-up of MPF shims.
//

---
 rtl/cci_mpf_fiu_mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_cci_mpf_fiu_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_fiu_mem_responder.sv
// cci_mpf_fiu_mem_responder
//
// FIU-side stand-in for the platform. It services AFU CCI requests from a
// local line memory. It is used for shim-level simulation and for loopback
// bring-up of MPF shims.
//   - c0Tx read requests return c0Rx read responses carrying the line data.
//   - c1Tx line writes and write fences return c1Rx write responses.
//   - Responses on each channel are strictly in request order.
//
// The cci_mpf_if to_afu view is flattened into plain ports:
//   clk, reset        : clock and synchronous active-high reset
//   afu_reset         : reset registered once, forwarded to the AFU
//   c0_tx_*           : read request (valid, addr, mdata, cl_len)
//   c1_tx_*           : write/fence request (valid, req_type, addr, mdata,
//                       cl_len, data)
//   c0_tx_alm_full    : read queue almost full (registered)
//   c1_tx_alm_full    : write queue almost full (registered)
//   c0_rx_*           : read response (rsp_valid, mmio valids tied 0,
//                       resp_type, mdata, cl_num, data)
//   c1_rx_*           : write response (rsp_valid, resp_type, mdata, format)
//   protocol_err      : sticky; set by a request to a full queue or by
//                       cl_len other than one line
//
// The c2Tx channel is not modelled.
//
// Optional feature macro: CCI_MPF_FIU_RSP_RANDOM_DELAY_EN
//   When defined, an LFSR adds 0..7 extra cycles to each head's issue
//   threshold, independently on each channel.

module cci_mpf_fiu_mem_responder #(
  parameter int MEM_ADDR_BITS  = 10,
  parameter int RD_FIFO_DEPTH  = 32,
  parameter int WR_FIFO_DEPTH  = 32,
  parameter int ALM_FULL_SLACK = 8,
  parameter int RD_LATENCY     = 4,
  parameter int WR_LATENCY     = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         afu_reset,
  input  logic         c0_tx_valid,
  input  logic [41:0]  c0_tx_addr,
  input  logic [15:0]  c0_tx_mdata,
  input  logic [1:0]   c0_tx_cl_len,
  input  logic         c1_tx_valid,
  input  logic [3:0]   c1_tx_req_type,
  input  logic [41:0]  c1_tx_addr,
  input  logic [15:0]  c1_tx_mdata,
  input  logic [1:0]   c1_tx_cl_len,
  input  logic [511:0] c1_tx_data,
  output logic         c0_tx_alm_full,
  output logic         c1_tx_alm_full,
  output logic         c0_rx_rsp_valid,
  output logic         c0_rx_mmio_rd_valid,
  output logic         c0_rx_mmio_wr_valid,
  output logic [3:0]   c0_rx_resp_type,
  output logic [15:0]  c0_rx_mdata,
  output logic [1:0]   c0_rx_cl_num,
  output logic [511:0] c0_rx_data,
  output logic         c1_rx_rsp_valid,
  output logic [3:0]   c1_rx_resp_type,
  output logic [15:0]  c1_rx_mdata,
  output logic         c1_rx_format,
  output logic         protocol_err
);

  localparam logic [3:0] REQ_WRFENCE = 4'h4;
  localparam logic [3:0] RSP_RDLINE  = 4'h0;
  localparam logic [3:0] RSP_WRLINE  = 4'h1;
  localparam logic [3:0] RSP_WRFENCE = 4'h4;
  localparam logic [1:0] CL_LEN_1    = 2'b00;

  localparam int RD_PTR_W  = $clog2(RD_FIFO_DEPTH);
  localparam int RD_CNT_W  = RD_PTR_W + 1;
  localparam int WR_PTR_W  = $clog2(WR_FIFO_DEPTH);
  localparam int WR_CNT_W  = WR_PTR_W + 1;
  localparam int MEM_LINES = 2 ** MEM_ADDR_BITS;

  logic         rst_any;
  logic [15:0]  now;
  logic [511:0] mem [MEM_LINES];

  logic [15:0]              rd_mdata_q [RD_FIFO_DEPTH];
  logic [MEM_ADDR_BITS-1:0] rd_line_q  [RD_FIFO_DEPTH];
  logic [15:0]              rd_ts_q    [RD_FIFO_DEPTH];
  logic [RD_PTR_W-1:0]      rd_head, rd_tail;
  logic [RD_CNT_W-1:0]      rd_count, rd_count_next;
  logic                     rd_full, rd_push, rd_pop;
  logic [15:0]              rd_age, rd_threshold;

  logic [15:0]              wr_mdata_q [WR_FIFO_DEPTH];
  logic                     wr_fence_q [WR_FIFO_DEPTH];
  logic [15:0]              wr_ts_q    [WR_FIFO_DEPTH];
  logic [WR_PTR_W-1:0]      wr_head, wr_tail;
  logic [WR_CNT_W-1:0]      wr_count, wr_count_next;
  logic                     wr_full, wr_push, wr_pop, wr_is_fence;
  logic [15:0]              wr_age, wr_threshold;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{c0_tx_addr[41:MEM_ADDR_BITS], c1_tx_addr[41:MEM_ADDR_BITS]};

  // Both our own reset and the forwarded AFU reset hold everything idle.
  // This gives the AFU a clean window after the forwarded reset drops.
  assign rst_any = reset | afu_reset;

  assign rd_full = (rd_count == RD_CNT_W'(RD_FIFO_DEPTH));
  assign wr_full = (wr_count == WR_CNT_W'(WR_FIFO_DEPTH));
  assign rd_push = c0_tx_valid & ~rst_any & ~rd_full;
  assign wr_push = c1_tx_valid & ~rst_any & ~wr_full;
  assign wr_is_fence = (c1_tx_req_type == REQ_WRFENCE);

  // Modular subtraction keeps the age correct across timestamp wrap.
  assign rd_age = now - rd_ts_q[rd_head];
  assign wr_age = now - wr_ts_q[wr_head];

  // The response register adds one cycle after issue.
  // Issue therefore fires one cycle before the nominal latency.
`ifdef CCI_MPF_FIU_RSP_RANDOM_DELAY_EN
  logic [15:0] lfsr;
  logic [2:0]  rd_extra, wr_extra;

  // The extra delay is resampled whenever a new entry can become the head.
  // That happens on a pop, or while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst_any) begin
      lfsr     <= 16'hACE1;
      rd_extra <= 3'd0;
      wr_extra <= 3'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (rd_pop || rd_count == '0) rd_extra <= lfsr[2:0];
      if (wr_pop || wr_count == '0) wr_extra <= lfsr[5:3];
    end
  end

  assign rd_threshold = 16'(RD_LATENCY - 1) + 16'(rd_extra);
  assign wr_threshold = 16'(WR_LATENCY - 1) + 16'(wr_extra);
`else
  assign rd_threshold = 16'(RD_LATENCY - 1);
  assign wr_threshold = 16'(WR_LATENCY - 1);
`endif

  // The write queue is strictly in order.
  // A fence therefore reaches the head only after every older write response.
  assign rd_pop = ~rst_any & (rd_count != '0) & (rd_age >= rd_threshold);
  assign wr_pop = ~rst_any & (wr_count != '0) & (wr_age >= wr_threshold);

  assign rd_count_next = rd_count + RD_CNT_W'(rd_push) - RD_CNT_W'(rd_pop);
  assign wr_count_next = wr_count + WR_CNT_W'(wr_push) - WR_CNT_W'(wr_pop);

  assign c0_rx_mmio_rd_valid = 1'b0;
  assign c0_rx_mmio_wr_valid = 1'b0;
  assign c0_rx_cl_num        = 2'd0;
  assign c0_rx_resp_type     = RSP_RDLINE;
  assign c1_rx_format        = 1'b0;

  // Writes commit on the accept edge. Reads sample memory at issue time.
  // Issue comes at least one cycle after accept, so a read sees any write
  // accepted on or before its own accept cycle.
  always_ff @(posedge clk) begin
    if (wr_push && !wr_is_fence) mem[c1_tx_addr[MEM_ADDR_BITS-1:0]] <= c1_tx_data;
    if (rd_pop) begin
      c0_rx_data  <= mem[rd_line_q[rd_head]];
      c0_rx_mdata <= rd_mdata_q[rd_head];
    end
    if (wr_pop) begin
      c1_rx_mdata     <= wr_mdata_q[wr_head];
      c1_rx_resp_type <= wr_fence_q[wr_head] ? RSP_WRFENCE : RSP_WRLINE;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_mdata_q[rd_tail] <= c0_tx_mdata;
      rd_line_q[rd_tail]  <= c0_tx_addr[MEM_ADDR_BITS-1:0];
      rd_ts_q[rd_tail]    <= now;
    end
    if (wr_push) begin
      wr_mdata_q[wr_tail] <= c1_tx_mdata;
      wr_fence_q[wr_tail] <= wr_is_fence;
      wr_ts_q[wr_tail]    <= now;
    end
  end

  always_ff @(posedge clk) begin
    afu_reset <= reset;
    now       <= reset ? 16'd0 : now + 16'd1;
    if (rst_any) begin
      rd_head         <= '0;
      rd_tail         <= '0;
      rd_count        <= '0;
      wr_head         <= '0;
      wr_tail         <= '0;
      wr_count        <= '0;
      c0_tx_alm_full  <= 1'b1;
      c1_tx_alm_full  <= 1'b1;
      c0_rx_rsp_valid <= 1'b0;
      c1_rx_rsp_valid <= 1'b0;
      protocol_err    <= 1'b0;
    end else begin
      if (rd_push) rd_tail <= rd_tail + RD_PTR_W'(1);
      if (rd_pop)  rd_head <= rd_head + RD_PTR_W'(1);
      if (wr_push) wr_tail <= wr_tail + WR_PTR_W'(1);
      if (wr_pop)  wr_head <= wr_head + WR_PTR_W'(1);
      rd_count        <= rd_count_next;
      wr_count        <= wr_count_next;
      c0_tx_alm_full  <= (rd_count_next >= RD_CNT_W'(RD_FIFO_DEPTH - ALM_FULL_SLACK));
      c1_tx_alm_full  <= (wr_count_next >= WR_CNT_W'(WR_FIFO_DEPTH - ALM_FULL_SLACK));
      c0_rx_rsp_valid <= rd_pop;
      c1_rx_rsp_valid <= wr_pop;
      // An over-length request is still serviced as a single line.
      if ((c0_tx_valid && (rd_full || c0_tx_cl_len != CL_LEN_1)) ||
          (c1_tx_valid && (wr_full || c1_tx_cl_len != CL_LEN_1)))
        protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cci_mpf_fiu_mem_responder.sv
// Testbench for cci_mpf_fiu_mem_responder.
// A long read latency is used so that back-to-back reads can fill the read
// queue. Expected responses are queued when requests are driven and are
// matched in order by a monitor on the falling clock edge.

module tb_cci_mpf_fiu_mem_responder;

  localparam int RD_LAT = 40;
  localparam int WR_LAT = 2;
  localparam int DEPTH  = 32;
  localparam int SLACK  = 8;

  localparam logic [3:0] REQ_WRLINE_I = 4'h1;
  localparam logic [3:0] REQ_WRFENCE  = 4'h4;
  localparam logic [3:0] RSP_RDLINE   = 4'h0;
  localparam logic [3:0] RSP_WRLINE   = 4'h1;
  localparam logic [3:0] RSP_WRFENCE  = 4'h4;

  typedef struct {
    logic [15:0]  mdata;
    logic [3:0]   rtype;
    logic [511:0] data;
    int           rsp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic afu_reset;
  logic c0_tx_valid, c1_tx_valid;
  logic [41:0] c0_tx_addr, c1_tx_addr;
  logic [15:0] c0_tx_mdata, c1_tx_mdata;
  logic [1:0] c0_tx_cl_len, c1_tx_cl_len;
  logic [3:0] c1_tx_req_type;
  logic [511:0] c1_tx_data;
  logic c0_tx_alm_full, c1_tx_alm_full;
  logic c0_rx_rsp_valid, c0_rx_mmio_rd_valid, c0_rx_mmio_wr_valid;
  logic [3:0] c0_rx_resp_type, c1_rx_resp_type;
  logic [15:0] c0_rx_mdata, c1_rx_mdata;
  logic [1:0] c0_rx_cl_num;
  logic [511:0] c0_rx_data;
  logic c1_rx_rsp_valid, c1_rx_format;
  logic protocol_err;

  exp_t rd_sb[$];
  exp_t wr_sb[$];
  logic [511:0] shadow [1024];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int last_wr_cyc = 0;

  cci_mpf_fiu_mem_responder #(
    .MEM_ADDR_BITS(10), .RD_FIFO_DEPTH(DEPTH), .WR_FIFO_DEPTH(DEPTH),
    .ALM_FULL_SLACK(SLACK), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk(clk), .reset(reset), .afu_reset(afu_reset),
    .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
    .c0_tx_cl_len(c0_tx_cl_len),
    .c1_tx_valid(c1_tx_valid), .c1_tx_req_type(c1_tx_req_type), .c1_tx_addr(c1_tx_addr),
    .c1_tx_mdata(c1_tx_mdata), .c1_tx_cl_len(c1_tx_cl_len), .c1_tx_data(c1_tx_data),
    .c0_tx_alm_full(c0_tx_alm_full), .c1_tx_alm_full(c1_tx_alm_full),
    .c0_rx_rsp_valid(c0_rx_rsp_valid), .c0_rx_mmio_rd_valid(c0_rx_mmio_rd_valid),
    .c0_rx_mmio_wr_valid(c0_rx_mmio_wr_valid), .c0_rx_resp_type(c0_rx_resp_type),
    .c0_rx_mdata(c0_rx_mdata), .c0_rx_cl_num(c0_rx_cl_num), .c0_rx_data(c0_rx_data),
    .c1_rx_rsp_valid(c1_rx_rsp_valid), .c1_rx_resp_type(c1_rx_resp_type),
    .c1_rx_mdata(c1_rx_mdata), .c1_rx_format(c1_rx_format),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A queued read stays inside the DUT until the edge that produces its
  // response.
  function automatic int rdOccupancy();
    int n = 0;
    foreach (rd_sb[i]) if (rd_sb[i].rsp_cyc > cyc) n++;
    return n;
  endfunction

  // Drive one cycle of requests from a falling edge. Queue the expected
  // responses, then return on the next falling edge with the valids dropped.
  task automatic applyStimulus(input bit rd, input logic [9:0] rd_line, input logic [15:0] rd_md,
                               input logic [1:0] rd_len, input bit wr, input logic [3:0] wr_ty,
                               input logic [9:0] wr_line, input logic [15:0] wr_md,
                               input logic [511:0] wr_dat);
    exp_t e;
    c0_tx_valid    = rd;
    c0_tx_addr     = {32'd0, rd_line};
    c0_tx_mdata    = rd_md;
    c0_tx_cl_len   = rd_len;
    c1_tx_valid    = wr;
    c1_tx_req_type = wr_ty;
    c1_tx_addr     = {32'd0, wr_line};
    c1_tx_mdata    = wr_md;
    c1_tx_cl_len   = 2'b00;
    c1_tx_data     = wr_dat;
    if (wr) begin
      if (wr_ty != REQ_WRFENCE) shadow[wr_line] = wr_dat;
      e.mdata   = wr_md;
      e.rtype   = (wr_ty == REQ_WRFENCE) ? RSP_WRFENCE : RSP_WRLINE;
      e.data    = '0;
      e.rsp_cyc = (last_wr_cyc + 1 > cyc + WR_LAT) ? last_wr_cyc + 1 : cyc + WR_LAT;
      last_wr_cyc = e.rsp_cyc;
      wr_sb.push_back(e);
    end
    if (rd && rdOccupancy() < DEPTH) begin
      e.mdata   = rd_md;
      e.rtype   = RSP_RDLINE;
      e.data    = shadow[rd_line];
      e.rsp_cyc = (last_rd_cyc + 1 > cyc + RD_LAT) ? last_rd_cyc + 1 : cyc + RD_LAT;
      last_rd_cyc = e.rsp_cyc;
      rd_sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    c0_tx_valid = 1'b0;
    c1_tx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Response monitor: each response must match the oldest expectation on
  // its channel.
  always @(negedge clk) begin
    exp_t e;
    if (c0_rx_rsp_valid === 1'b1) begin
      if (rd_sb.size() == 0) checkOutput("c0_unexpected_rsp", 512'(1), 512'(0));
      else begin
        e = rd_sb.pop_front();
        checkOutput("c0_mdata", 512'(c0_rx_mdata), 512'(e.mdata));
        checkOutput("c0_resp_type", 512'(c0_rx_resp_type), 512'(e.rtype));
        checkOutput("c0_data", c0_rx_data, e.data);
        checkOutput("c0_cl_num_mmio", 512'({c0_rx_cl_num, c0_rx_mmio_rd_valid, c0_rx_mmio_wr_valid}), 512'(0));
`ifdef CCI_MPF_FIU_RSP_RANDOM_DELAY_EN
        checkOutput("c0_not_early", 512'(cyc >= e.rsp_cyc), 512'(1));
`else
        checkOutput("c0_rsp_cycle", 512'(cyc), 512'(e.rsp_cyc));
`endif
      end
    end
    if (c1_rx_rsp_valid === 1'b1) begin
      if (wr_sb.size() == 0) checkOutput("c1_unexpected_rsp", 512'(1), 512'(0));
      else begin
        e = wr_sb.pop_front();
        checkOutput("c1_mdata", 512'(c1_rx_mdata), 512'(e.mdata));
        checkOutput("c1_resp_type", 512'(c1_rx_resp_type), 512'(e.rtype));
        checkOutput("c1_format", 512'(c1_rx_format), 512'(0));
`ifdef CCI_MPF_FIU_RSP_RANDOM_DELAY_EN
        checkOutput("c1_not_early", 512'(cyc >= e.rsp_cyc), 512'(1));
`else
        checkOutput("c1_rsp_cycle", 512'(cyc), 512'(e.rsp_cyc));
`endif
      end
    end
  end

  initial begin
    logic [511:0] a5_line;
    logic [511:0] new_line;
    a5_line  = {64{8'hA5}};
    new_line = {16{32'h1234_5678}};
    for (int i = 0; i < 1024; i++) shadow[i] = '0;
    reset = 1'b1;
    c0_tx_valid = 1'b0;
    c1_tx_valid = 1'b0;
    c0_tx_addr = '0; c0_tx_mdata = '0; c0_tx_cl_len = '0;
    c1_tx_addr = '0; c1_tx_mdata = '0; c1_tx_cl_len = '0;
    c1_tx_req_type = REQ_WRLINE_I; c1_tx_data = '0;

    idle(4);
    checkOutput("reset_alm_full", 512'({c0_tx_alm_full, c1_tx_alm_full}), 512'(2'b11));
    checkOutput("reset_valids", 512'({c0_rx_rsp_valid, c1_rx_rsp_valid}), 512'(0));
    checkOutput("reset_perr", 512'(protocol_err), 512'(0));
    checkOutput("reset_afu_reset", 512'(afu_reset), 512'(1));
    reset = 1'b0;
    idle(3);
    checkOutput("post_reset_alm_full", 512'({c0_tx_alm_full, c1_tx_alm_full}), 512'(0));

    $display("[TB] write line 3 then read it back");
    applyStimulus(0, 10'd0, 16'd0, 2'b00, 1, REQ_WRLINE_I, 10'd3, 16'd7, a5_line);
    applyStimulus(1, 10'd3, 16'd9, 2'b00, 0, REQ_WRLINE_I, 10'd0, 16'd0, '0);
    idle(RD_LAT + 5);

    $display("[TB] same-cycle read and write of line 5");
    applyStimulus(1, 10'd5, 16'd20, 2'b00, 1, REQ_WRLINE_I, 10'd5, 16'd21, new_line);
    idle(RD_LAT + 5);

    $display("[TB] writes followed by a fence");
    for (int i = 1; i <= 3; i++)
      applyStimulus(0, 10'd0, 16'd0, 2'b00, 1, REQ_WRLINE_I, 10'(9 + i), 16'(i), {16{32'(i * 32'h0101_0101)}});
    applyStimulus(0, 10'd0, 16'd0, 2'b00, 1, REQ_WRFENCE, 10'd0, 16'd4, '0);
    idle(10);

    $display("[TB] preload lines 0..31");
    for (int i = 0; i < 32; i++)
      applyStimulus(0, 10'd0, 16'd0, 2'b00, 1, REQ_WRLINE_I, 10'(i), 16'(100 + i), {16{32'($urandom)}});
    idle(10);

    $display("[TB] 32 back-to-back reads then one more into a full queue");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 10'(i), 16'(i), 2'b00, 0, REQ_WRLINE_I, 10'd0, 16'd0, '0);
      checkOutput($sformatf("c0_alm_full_%0d", i), 512'(c0_tx_alm_full), 512'(rdOccupancy() >= DEPTH - SLACK));
    end
    checkOutput("perr_after_32", 512'(protocol_err), 512'(0));
`ifndef CCI_MPF_FIU_RSP_RANDOM_DELAY_EN
    applyStimulus(1, 10'd0, 16'd99, 2'b00, 0, REQ_WRLINE_I, 10'd0, 16'd0, '0);
    checkOutput("perr_overflow", 512'(protocol_err), 512'(1));
`endif
    idle(RD_LAT + 40);
    checkOutput("rd_sb_drained_1", 512'(rd_sb.size()), 512'(0));
`ifndef CCI_MPF_FIU_RSP_RANDOM_DELAY_EN
    checkOutput("perr_sticky", 512'(protocol_err), 512'(1));
`endif

    $display("[TB] reset with reads in flight");
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 10'(i), 16'(200 + i), 2'b00, 0, REQ_WRLINE_I, 10'd0, 16'd0, '0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_sb.delete();
    wr_sb.delete();
    last_rd_cyc = 0;
    last_wr_cyc = 0;
    reset = 1'b0;
    checkOutput("mid_reset_alm_1", 512'({c0_tx_alm_full, c1_tx_alm_full}), 512'(2'b11));
    checkOutput("mid_reset_afu_reset", 512'(afu_reset), 512'(1));
    checkOutput("mid_reset_perr", 512'(protocol_err), 512'(0));
    idle(1);
    checkOutput("mid_reset_alm_2", 512'({c0_tx_alm_full, c1_tx_alm_full}), 512'(2'b11));
    idle(1);
    checkOutput("mid_reset_alm_3", 512'({c0_tx_alm_full, c1_tx_alm_full}), 512'(0));
    checkOutput("mid_reset_afu_reset_low", 512'(afu_reset), 512'(0));
    idle(RD_LAT + 10);

    $display("[TB] multi-line read after reset, memory retained");
    applyStimulus(1, 10'd3, 16'd55, 2'b01, 0, REQ_WRLINE_I, 10'd0, 16'd0, '0);
    checkOutput("perr_cl_len", 512'(protocol_err), 512'(1));
    idle(RD_LAT + 10);

    checkOutput("rd_sb_drained_final", 512'(rd_sb.size()), 512'(0));
    checkOutput("wr_sb_drained_final", 512'(wr_sb.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
